tank_vertical_ctrl: RTL and testbench

TANK_VERTICAL_CTRL -- requirements
Module: tank_vertical_ctrl

---
 rtl/tank_vertical_ctrl.sv | 63 ++++++
 tb/tb_tank_vertical_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tank_vertical_ctrl.sv
// tank_vertical_ctrl: per-frame tank Y tracking over flat floor, up/down ramps and a
// gravity settle back to the bottom floor, with registered state and status outputs.
module tank_vertical_ctrl #(
  parameter int Y_LOW     = 420,
  parameter int RAMP_H    = 28,
  parameter int STEP      = 1,
  parameter int FALL_STEP = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] terrain,
  input  logic       move_en,
  output logic [9:0] tankY,
  output logic       grounded,
  output logic [1:0] state,
  output logic       y_changed
);
  localparam int Y_HIGH = Y_LOW - RAMP_H;
  typedef enum logic [1:0] {LEVEL = 2'b00, CLIMB = 2'b01, DESCEND = 2'b10, SETTLE = 2'b11} st_t;
  st_t st, ns;
  logic [9:0] ny, y_up, y_dn, y_fall;
  logic up, dn, at_end;
  // terrain 11 decodes as neither ramp, so it behaves exactly like flat floor
  assign up     = terrain == 2'b10;
  assign dn     = terrain == 2'b01;
  assign at_end = (tankY == 10'(Y_HIGH)) || (tankY == 10'(Y_LOW));
  assign y_up   = (int'(tankY) >= Y_HIGH + STEP) ? 10'(int'(tankY) - STEP) : 10'(Y_HIGH);
  assign y_dn   = (int'(tankY) + STEP >= Y_LOW) ? 10'(Y_LOW) : 10'(int'(tankY) + STEP);
  assign y_fall = (int'(tankY) + FALL_STEP >= Y_LOW) ? 10'(Y_LOW) : 10'(int'(tankY) + FALL_STEP);
  assign state  = st;
  always_comb begin
    ns = st;
    ny = tankY;
    unique case (st)
      LEVEL:   ns = (move_en && up) ? CLIMB : (move_en && dn) ? DESCEND : LEVEL;
      CLIMB:
        if (up) ny = move_en ? y_up : tankY;
        else ns = (move_en && dn) ? DESCEND : at_end ? LEVEL : SETTLE;
      DESCEND:
        if (dn) ny = move_en ? y_dn : tankY;
        else ns = (move_en && up) ? CLIMB : at_end ? LEVEL : SETTLE;
      SETTLE:
        if (move_en && (up || dn)) ns = up ? CLIMB : DESCEND;
        else begin
          ny = y_fall;
          ns = (y_fall == 10'(Y_LOW)) ? LEVEL : SETTLE;
        end
    endcase
  end
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      st        <= LEVEL;
      tankY     <= 10'(Y_LOW);
      grounded  <= 1'b1;
      y_changed <= 1'b0;
    end else begin
      st        <= ns;
      tankY     <= ny;
      grounded  <= ns == LEVEL;
      y_changed <= ny != tankY;
    end
  end
endmodule

// File: tb/tb_tank_vertical_ctrl.sv
// tb_tank_vertical_ctrl: scenario tasks push expected {tankY,state,grounded,y_changed}
// into a scoreboard queue per edge and pop/compare after the DUT updates.
module tb_tank_vertical_ctrl;
  logic frame_clk = 0, Reset = 0, move_en = 0;
  logic [1:0] terrain = 2'b00, state;
  logic [9:0] tankY;
  logic grounded, y_changed;
  logic [13:0] sb[$];
  logic [13:0] e, got;
  int checks = 0, errors = 0;
  int py = 420;

  tank_vertical_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .terrain(terrain), .move_en(move_en),
    .tankY(tankY), .grounded(grounded), .state(state), .y_changed(y_changed)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // pushes the expected post-edge outputs, then applies inputs and advances one edge
  task automatic drive(input logic r, input logic [1:0] t, input logic m, input int y, input logic [1:0] st);
    logic yc;
    yc = r && (y != py);
    py = y;
    sb.push_back({10'(y), st, st == 2'b00, yc});
    Reset = r; terrain = t; move_en = m;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      drive(0, 2'b10, 1, 420, 2'b00);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  task automatic test_full_climb;
    for (int k = 1; k <= 41; k++) begin
      if (k <= 40) drive(1, 2'b10, 1, (420 - (k - 1) < 392) ? 392 : 420 - (k - 1), 2'b01);
      else drive(0, 2'b10, 1, 420, 2'b00);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL full_climb[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  task automatic test_partial_settle;
    for (int k = 1; k <= 16; k++) begin
      if (k <= 11) drive(1, 2'b10, 1, 420 - (k - 1), 2'b01);
      else if (k == 12) drive(1, 2'b00, 1, 410, 2'b11);
      else if (k == 13) drive(1, 2'b00, 0, 414, 2'b11);
      else if (k == 14) drive(1, 2'b11, 0, 418, 2'b11);
      else drive(1, 2'b00, 0, 420, 2'b00);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL partial_settle[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  task automatic test_stall_reserved;
    for (int k = 1; k <= 30; k++) begin
      if (k <= 21) drive(1, 2'b10, 1, 420 - (k - 1), 2'b01);
      else if (k <= 26) drive(1, 2'b10, 0, 400, 2'b01);
      else if (k == 27) drive(0, 2'b00, 0, 420, 2'b00);
      else drive(1, 2'b11, 1, 420, 2'b00);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall_reserved[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  task automatic test_direction_swap;
    for (int k = 1; k <= 34; k++) begin
      if (k <= 16) drive(1, 2'b10, 1, 420 - (k - 1), 2'b01);
      else if (k == 17) drive(1, 2'b01, 1, 405, 2'b10);
      else if (k <= 32) drive(1, 2'b01, 1, 405 + (k - 17), 2'b10);
      else if (k == 33) drive(1, 2'b01, 1, 420, 2'b10);
      else drive(1, 2'b00, 0, 420, 2'b00);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL direction_swap[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 23; k++) begin
      if (k <= 19) drive(1, 2'b10, 1, 420 - (k - 1), 2'b01);
      else if (k == 20) drive(1, 2'b00, 0, 402, 2'b11);
      else if (k == 21) drive(0, 2'b00, 0, 420, 2'b00);
      else if (k == 22) drive(0, 2'b01, 1, 420, 2'b00);
      else drive(1, 2'b10, 1, 420, 2'b01);
      e = sb.pop_front(); got = {tankY, state, grounded, y_changed}; checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got y=%0d st/g/yc=%b expected y=%0d st/g/yc=%b", k, got[13:4], got[3:0], e[13:4], e[3:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_full_climb;
    test_partial_settle;
    test_stall_reserved;
    test_direction_swap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
